// File: rtl/sm_hex_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// sm_hex_display_scan : multiplexed hex 7-segment scanner with frame snapshot
// Revision 1.0 - initial release
// ==========================================================================
module sm_hex_display_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                  clkIn,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  hold,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   snap_num_q, snap_num_d;
  logic [DIGITS-1:0]     snap_dot_q, snap_dot_d;
  logic                  wrap_q, wrap_d;
  logic                  frame_q, frame_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dot_q, dot_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  cnt_wrap, idx_wrap;
  logic                  all_zero, blank, in_guard;
  logic [DIGITS-1:0]     lz;
  logic [3:0]            nibble;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Scan counters, snapshot and frame marker
  always_comb begin
    cnt_wrap   = (cnt_q == CNT_LAST);
    idx_wrap   = cnt_wrap && (idx_q == IDX_LAST);
    cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    snap_num_d = snap_num_q;
    snap_dot_d = snap_dot_q;
    if (idx_wrap && !hold) begin
      snap_num_d = number;
      snap_dot_d = dots;
    end
    wrap_d  = idx_wrap;
    // frame lines up with the first registered outputs built from the new snapshot
    frame_d = wrap_q;
  end

  // Display decode from the current (idx, cnt) and snapshot
  always_comb begin
    all_zero = 1'b1;
    lz       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (snap_num_q[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end
    nibble   = snap_num_q[{idx_q, 2'b00} +: 4];
    blank    = BLANK_LZ && (idx_q != '0) && lz[idx_q];
    in_guard = (GUARD != 0) && (cnt_q < GUARD_CNT);
    seg_d    = blank ? 7'h00 : glyph(nibble);
    dot_d    = !blank && snap_dot_q[idx_q];
    an_d     = '0;
    if (!blank && !in_guard) an_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_num_q <= '0;
      snap_dot_q <= '0;
      wrap_q     <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= '0;
      dot_q      <= 1'b0;
      an_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_num_q <= snap_num_d;
      snap_dot_q <= snap_dot_d;
      wrap_q     <= wrap_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      dot_q      <= dot_d;
      an_q       <= an_d;
    end
  end

  assign seven_segments = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dot            = dot_q ^ SEG_ACTIVE_LOW;
  assign anodes         = an_q ^ {DIGITS{AN_ACTIVE_LOW}};
  assign frame          = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_hex_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_sm_hex_display_scan : directed self-checking bench, 4 digits, div 4
// Revision 1.0 - initial release
// ==========================================================================
module tb_sm_hex_display_scan;

  localparam logic [6:0] S0  = 7'h40;
  localparam logic [6:0] S1  = 7'h79;
  localparam logic [6:0] S2  = 7'h24;
  localparam logic [6:0] S5  = 7'h12;
  localparam logic [6:0] SA  = 7'h08;
  localparam logic [6:0] SF  = 7'h0E;
  localparam logic [6:0] OFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] number;
  logic [3:0]  dots;
  logic        hold;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [3:0]  anodes;
  logic        frame;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  sm_hex_display_scan #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) dut (
    .clkIn(clk), .rst_n(rst_n), .number(number), .dots(dots), .hold(hold),
    .seven_segments(seven_segments), .dot(dot), .anodes(anodes), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // cyc = number of rising edges since reset release; outputs show state cyc-1
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [3:0] exp_an(input int cy, input logic [3:0] lit);
    int s, c;
    s = ((cy - 1) / 4) % 4;
    c = (cy - 1) % 4;
    if (!lit[s] || c == 0) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic exp_frame(input int cy);
    return (cy >= 17) && (((cy - 1) % 16) == 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; number = 16'h0; dots = 4'h0; hold = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (anodes !== 4'b1111) begin n_bad++; $display("FAIL reset_anodes got=%b exp=%b", anodes, 4'b1111); end
    n_cmp++; if (seven_segments !== OFF) begin n_bad++; $display("FAIL reset_seg got=%h exp=%h", seven_segments, OFF); end
    n_cmp++; if (dot !== 1'b1) begin n_bad++; $display("FAIL reset_dot got=%b exp=1", dot); end
    n_cmp++; if (frame !== 1'b0) begin n_bad++; $display("FAIL reset_frame got=%b exp=0", frame); end
    number = 16'h12AF;
    rst_n  = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_scan();
    logic [6:0] g [4];
    logic [6:0] eseg;
    logic [3:0] lit;
    int s;
    g[0] = SF; g[1] = SA; g[2] = S2; g[3] = S1;
    for (int k = 0; k < 32; k++) begin
      tick();
      s = ((cyc - 1) / 4) % 4;
      if (cyc <= 16) begin lit = 4'b0001; eseg = (s == 0) ? S0 : OFF; end
      else begin lit = 4'b1111; eseg = g[s]; end
      n_cmp++; if (anodes !== exp_an(cyc, lit)) begin n_bad++; $display("FAIL scan_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_an(cyc, lit)); end
      n_cmp++; if (seven_segments !== eseg) begin n_bad++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seven_segments, eseg); end
      n_cmp++; if (dot !== 1'b1) begin n_bad++; $display("FAIL scan_dot cyc=%0d got=%b exp=1", cyc, dot); end
      n_cmp++; if (frame !== exp_frame(cyc)) begin n_bad++; $display("FAIL scan_frame cyc=%0d got=%b exp=%b", cyc, frame, exp_frame(cyc)); end
    end
  endtask

  task automatic test_guard();
    int off_n, on_n;
    for (int s = 0; s < 4; s++) begin
      off_n = 0; on_n = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (anodes === 4'b1111) off_n++;
        else if (anodes === ~(4'b0001 << s)) on_n++;
        if (cyc == 33) begin
          n_cmp++; if (frame !== 1'b1) begin n_bad++; $display("FAIL guard_frame cyc=%0d got=%b exp=1", cyc, frame); end
        end
      end
      n_cmp++; if (off_n !== 1) begin n_bad++; $display("FAIL guard_off_cycles slot=%0d got=%0d exp=1", s, off_n); end
      n_cmp++; if (on_n !== 3) begin n_bad++; $display("FAIL guard_on_cycles slot=%0d got=%0d exp=3", s, on_n); end
    end
  endtask

  task automatic test_lz();
    logic [6:0] ga [4];
    logic [6:0] gb [4];
    logic       edot;
    int s;
    ga[0] = S0; ga[1] = S5; ga[2] = OFF; ga[3] = OFF;
    gb[0] = S0; gb[1] = OFF; gb[2] = OFF; gb[3] = OFF;
    number = 16'h0050; dots = 4'b0100;
    repeat (16) tick();
    number = 16'h0000; dots = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      tick();
      s = ((cyc - 1) / 4) % 4;
      n_cmp++; if (anodes !== exp_an(cyc, 4'b0011)) begin n_bad++; $display("FAIL lz50_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_an(cyc, 4'b0011)); end
      n_cmp++; if (seven_segments !== ga[s]) begin n_bad++; $display("FAIL lz50_seg cyc=%0d got=%h exp=%h", cyc, seven_segments, ga[s]); end
      n_cmp++; if (dot !== 1'b1) begin n_bad++; $display("FAIL lz50_dot cyc=%0d got=%b exp=1", cyc, dot); end
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      s = ((cyc - 1) / 4) % 4;
      edot = (s == 0) ? 1'b0 : 1'b1;
      n_cmp++; if (anodes !== exp_an(cyc, 4'b0001)) begin n_bad++; $display("FAIL lz0_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_an(cyc, 4'b0001)); end
      n_cmp++; if (seven_segments !== gb[s]) begin n_bad++; $display("FAIL lz0_seg cyc=%0d got=%h exp=%h", cyc, seven_segments, gb[s]); end
      n_cmp++; if (dot !== edot) begin n_bad++; $display("FAIL lz0_dot cyc=%0d got=%b exp=%b", cyc, dot, edot); end
      n_cmp++; if (frame !== exp_frame(cyc)) begin n_bad++; $display("FAIL lz0_frame cyc=%0d got=%b exp=%b", cyc, frame, exp_frame(cyc)); end
    end
  endtask

  task automatic test_hold();
    logic [6:0] fexp [5];
    fexp[0] = S1; fexp[1] = S2; fexp[2] = S1; fexp[3] = S1; fexp[4] = S2;
    number = 16'h1111; dots = 4'h0;
    repeat (16) tick();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 16; k++) begin
        tick();
        n_cmp++; if (seven_segments !== fexp[f]) begin n_bad++; $display("FAIL hold_seg frame=%0d cyc=%0d got=%h exp=%h", f, cyc, seven_segments, fexp[f]); end
        n_cmp++; if (anodes !== exp_an(cyc, 4'b1111)) begin n_bad++; $display("FAIL hold_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_an(cyc, 4'b1111)); end
        n_cmp++; if (frame !== exp_frame(cyc)) begin n_bad++; $display("FAIL hold_frame cyc=%0d got=%b exp=%b", cyc, frame, exp_frame(cyc)); end
        case (cyc)
          120: number = 16'h2222;
          132: hold = 1'b1;
          134: hold = 1'b0;
          136: number = 16'h1111;
          152: begin number = 16'h2222; hold = 1'b1; end
          164: hold = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] eseg;
    logic [3:0] lit;
    int s;
    repeat (10) tick();
    n_cmp++; if (anodes !== 4'b1011) begin n_bad++; $display("FAIL mid_pre_anodes got=%b exp=%b", anodes, 4'b1011); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (anodes !== 4'b1111) begin n_bad++; $display("FAIL mid_async_anodes got=%b exp=%b", anodes, 4'b1111); end
    n_cmp++; if (seven_segments !== OFF) begin n_bad++; $display("FAIL mid_async_seg got=%h exp=%h", seven_segments, OFF); end
    n_cmp++; if (dot !== 1'b1) begin n_bad++; $display("FAIL mid_async_dot got=%b exp=1", dot); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      s = ((cyc - 1) / 4) % 4;
      if (cyc <= 16) begin lit = 4'b0001; eseg = (s == 0) ? S0 : OFF; end
      else begin lit = 4'b1111; eseg = S2; end
      n_cmp++; if (anodes !== exp_an(cyc, lit)) begin n_bad++; $display("FAIL mid_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_an(cyc, lit)); end
      n_cmp++; if (seven_segments !== eseg) begin n_bad++; $display("FAIL mid_seg cyc=%0d got=%h exp=%h", cyc, seven_segments, eseg); end
      n_cmp++; if (frame !== exp_frame(cyc)) begin n_bad++; $display("FAIL mid_frame cyc=%0d got=%b exp=%b", cyc, frame, exp_frame(cyc)); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_guard();
    test_lz();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_hex_display_scan.md
# sm_hex_display_scan

Parametrised, time-multiplexed seven-segment scanner for board top levels: drives `DIGITS` hex digits from a packed number bus, with an internal refresh prescaler and a per-frame snapshot so the display never tears. It adds leading-zero blanking, per-digit dot inputs, selectable segment/anode polarity, an anti-ghosting guard interval and a hold (freeze) input. It sits between the CPU debug register output and the board's segment/anode pins.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, at least 2.
- `GUARD`, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < REFRESH_DIV.
- `SEG_ACTIVE_LOW`, 1: when 1, `seven_segments` and `dot` are inverted at the output.
- `AN_ACTIVE_LOW`, 1: when 1, `anodes` are inverted at the output.
- `BLANK_LZ`, 1: enables leading-zero blanking.
- `clkIn`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `number`  in  4*DIGITS  value to display; nibble k drives digit k, and digit 0 is the least significant.
- `dots`  in  DIGITS  per-digit decimal point request.
- `hold`  in  1  while high, frame snapshots are suppressed and the display stays frozen.
- `seven_segments`  out  7  segments, bit order g..a ([6]=g, [0]=a).
- `dot`  out  1  decimal point.
- `anodes`  out  DIGITS  one-hot digit select.
- `frame`  out  1  one-cycle pulse on each frame wrap.

## Operation
- `cnt` is the prescaler. It counts 0..REFRESH_DIV-1 and then wraps.
- `idx` is the digit index. It advances when `cnt` wraps, and goes from DIGITS-1 back to 0.
- A frame lasts DIGITS*REFRESH_DIV cycles.
- Snapshot register `snap` (number plus dots):
  - loads on the clock edge where `idx` wraps DIGITS-1 to 0, provided `hold`=0 in that cycle;
  - never loads at any other time.
  - A change to `number` mid-frame is therefore shown from the next frame boundary.
- Glyph map, active-high, a..g with a in bit 0:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero blanking applies when BLANK_LZ=1. Digit i>0 is blank when `snap` nibbles DIGITS-1 down to i are all zero. Digit 0 is never blank, so a value of 0 shows as a single "0".
- A blank digit drives segments off, dot off and its anode off. The slot still consumes its time.
- During a guard interval (`cnt` < GUARD) all anodes are off. Segments already show the new digit.
- Polarity inversion is applied last, on the registered outputs.

## Timing
- Reset is asynchronous and takes effect immediately. Reset values:
  - `cnt`=0, `idx`=0, `snap`=0;
  - all anodes inactive, segments off, `dot` off, `frame`=0;
  - "inactive" and "off" mean the physical levels set by the polarity parameters (e.g. `anodes`=all 1 and `seven_segments`=7'h7F when active-low).
- Outputs are registered. In the cycle after the internal state is (`idx`=i, `cnt`=c), the outputs reflect i and c. Latency is 1 cycle.
- `frame` is high for exactly the one cycle following the `idx` wrap edge, i.e. coincident with the first outputs that use the new snapshot.
- Reset released mid-operation: scanning restarts at digit 0, `cnt`=0, and the display shows the zero snapshot until the first frame wrap.
- `hold` is sampled only at the wrap edge. Pulses on `hold` between wraps have no effect.

## Test plan
Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=4, GUARD=1, both active-low, BLANK_LZ=1.

- **Reset:** hold `rst_n` low. Required: `anodes`=4'b1111, `seven_segments`=7'h7F, `dot`=1, `frame`=0. Release reset with `number`=16'h12AF and run 2 frames.
- **Scan order:** continuing from reset, the first frame shows "0" on digit 0 only. From the second frame:
  - digit 0 shows F (7'b0001110) with `anodes`=4'b1110 for cycles 2-4 of its slot;
  - digit 3 shows 1 (7'b1111001);
  - `frame` pulses every 16 cycles.
- **Guard:** in every slot, `anodes`=4'b1111 for exactly 1 cycle, then the selected anode is active for 3 cycles.
- **Leading-zero blanking:**
  - `number`=16'h0050: digits 3 and 2 are anode-off; digit 1 shows 5 (7'b0010010); digit 0 shows 0 (7'b1000000).
  - `number`=0: only digit 0 lit, showing 0.
  - `dots`=4'b0100 with `number`=16'h0050: `dot`=0 is driven only during digit 2's slot if that digit is non-blank, so with this value the dot is not shown.
- **Hold and no tearing:**
  - Change `number` from 16'h1111 to 16'h2222 mid-frame: all 4 digits show 1 until the next `frame` pulse, then all show 2.
  - With `hold`=1 across the wrap, 1s persist.
  - Drop `hold`: 2s appear after the following wrap.
- **Reset mid-scan:** pull `rst_n` low while digit 2 is active. Outputs go inactive in the same cycle, before any clock edge. After release, the scan resumes at digit 0.
